i2c_cmos_master: RTL and testbench
==================================

# i2c_cmos_master

Byte-level I2C initiator for the CMOS/RTC EEPROM path. It runs random-address single-byte writes and reads against the 24C0x-style responder (device address 7'h50). It drives SCL and SDA as split open-drain signals and presents a simple req/done handshake to host-side logic, such as the CMOS save/restore sequencer or a self-test. It sits in the `clk_sys` domain beside the EEPROM responder and connects to it directly (`scl_o` to SCL, `sda_o` to SDA_in, SDA_out to `sda_i`), wire-ANDed with any other initiator.

## Interface
Parameters:
- `CLK_HZ`, default 42000000: `clk_sys` frequency.
- `I2C_HZ`, default 100000: SCL bit rate.
- `DIV` = `CLK_HZ/(4*I2C_HZ)`, derived: clocks per quarter-bit. The default is 105; it must be ≥ 2.

Ports (direction, width, meaning):
- `clk_sys` — in, 1. System clock.
- `reset_n` — in, 1. Asynchronous, active-low reset.
- `req` — in, 1. Start a transaction. Sampled only in IDLE.
- `we` — in, 1. 1 = write, 0 = read. Latched at accept.
- `addr` — in, 8. EEPROM word address. Latched at accept.
- `wdata` — in, 8. Write data. Latched at accept.
- `rdata` — out, 8. Read result. Valid from the `done` pulse until the next accept.
- `busy` — out, 1. High from accept until the cycle `done` is asserted.
- `done` — out, 1. One-cycle completion pulse.
- `nack` — out, 1. Set with `done` if any responder ACK was missing. Cleared at the next accept.
- `scl_o` — out, 1. SCL drive; 1 = released.
- `sda_o` — out, 1. SDA drive; 1 = released.
- `sda_i` — in, 1. Resolved SDA. It comes from the same clock domain, so no synchroniser is used.

## Operation
- **Reset values:** `scl_o`=1, `sda_o`=1, `busy`=0, `done`=0, `nack`=0, `rdata`=0, state IDLE, quarter counter 0.
- **Slot structure:** the transaction is a sequence of slots, each 4 quarters (q0..q3) of `DIV` clocks.
  - Data and ACK bit: SDA is set at q0 with SCL low; SCL is high for q1–q2; SCL is low at q3.
  - SDA is sampled on the last clock of q2.
- **Special slots:**
  - START: SDA=1 and SCL=1 for q0–q1; SDA=0 at q2; SCL=0 at q3.
  - RESTART: SCL=0 with SDA=1 at q0; SCL=1 at q1; SDA=0 at q2; SCL=0 at q3.
  - STOP: SDA=0 at q0; SCL=1 at q1; SDA=1 at q2; q3 holds SCL=1 and SDA=1.
- **States:** IDLE, START, TX (8 bits, MSB first), RACK, RESTART, RX (8 bits), MNACK, STOP, FIN.
- **Write sequence:** START, TX 0xA0, RACK, TX `addr`, RACK, TX `wdata`, RACK, STOP, FIN.
- **Read sequence:** START, TX 0xA0, RACK, TX `addr`, RACK, RESTART, TX 0xA1, RACK, RX, MNACK (SDA released), STOP, FIN.
- **Byte index:** a 2-bit index selects the next TX byte after each RACK.
- **Missing ACK:** RACK samples `sda_i`=1 → set the internal nack flag and go directly to STOP. The remaining bytes are skipped.
- **FIN:** one clock. Assert `done` and `nack`, deassert `busy`, return to IDLE.
- **RX:** shift `sda_i` into `rdata` in the q2 sample order, MSB first.
- **Ignored inputs:** `req` while `busy` is ignored. `req` held high re-triggers one clock after FIN.
- **Reset mid-transaction:** both lines are released immediately; no STOP is generated.

## Timing
- **Accept:** `req` is accepted on the clock edge where the state is IDLE and `req`=1. `busy` goes high on that edge, and the quarter counter restarts at 0.
- **Write latency:** 29 slots = 116·`DIV` clocks. `done` is high on the cycle at accept + 116·`DIV`, which is 12180 at the defaults.
- **Read latency:** 39 slots = 156·`DIV` clocks, which is 16380 at the defaults.
- **Early NACK:** the transaction ends after the failing RACK slot + STOP + FIN.
  - Example: NACK on the control byte gives 1+9+1 slots, so `done` is at 44·`DIV`.
- **SCL stretching:** not supported. `sda_i` is never examined during q0, q1 or q3.

## Structure
- Package `i2c_cmos_pkg` holds:
  - the state enum;
  - `EEP_DEV` = 7'h50;
  - the slot-count constants WR_SLOTS=29 and RD_SLOTS=39, also used by the bench.
- Sub-module `i2c_qtick` is the `DIV` counter. It has a synchronous restart input and emits one-clock quarter ticks plus a 2-bit quarter index.
- Top level: FSM, shift register, bit counter.

## Test plan
- **Write:** write `addr`=0x40, `wdata`=0x5A against the EEPROM_24C0x model (E_id=0) → `done` at 116·`DIV`, `nack`=0, model RAM[0x40]=0x5A. Monitor checks the START/STOP edges and the byte sequence A0,40,5A.
- **Read:** preload RAM[0x7F]=0xC3, then read 0x7F → `done` at 156·`DIV`, `rdata`=0xC3, master NACK seen on the 9th RX clock.
- **No responder:** no responder (`sda_i` tied 1) → `nack`=1, `done` at 44·`DIV`, STOP observed, lines released.
- **Reset mid-transaction:** assert `reset_n` low in the middle of the second TX byte → `scl_o`=`sda_o`=1 and `busy`=0 asynchronously. The next write to 0x10 completes correctly.
- **Back-to-back:** `req` held high for two writes with `busy` pulsed → second accept one clock after the first `done`. `req` pulses during `busy` are ignored; exactly 2 `done` pulses.
- **Minimum divider:** `DIV`=2 build, full write then read of address 0xFF → data round-trips and the latencies scale (232 and 312 clocks).

Source files
------------

// File: rtl/i2c_cmos_pkg.sv
// Shared types and constants for the CMOS/RTC EEPROM I2C initiator.
// Slot counts are whole transaction lengths, START through STOP.
package i2c_cmos_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StTx,
    StRack,
    StRestart,
    StRx,
    StMnack,
    StStop,
    StFin
  } state_e;

  localparam logic [6:0] EEP_DEV = 7'h50;

  localparam int unsigned WR_SLOTS = 29;
  localparam int unsigned RD_SLOTS = 39;

  // Control byte: device address plus the R/W bit (1 = read).
  function automatic logic [7:0] ctrl_byte(input logic rd);
    return {EEP_DEV, rd};
  endfunction

  // Byte sent in the TX phase selected by the byte index.
  function automatic logic [7:0] tx_byte(input logic [1:0] idx, input logic we,
                                         input logic [7:0] addr, input logic [7:0] wdata);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = ctrl_byte(1'b0);
      2'd1:    b = addr;
      default: b = we ? wdata : ctrl_byte(1'b1);
    endcase
    return b;
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-bit timebase: one-clock tick every DIV clocks plus a 2-bit quarter index.
// A synchronous restart holds both the divider and the quarter index at zero.
module i2c_qtick #(
  parameter int unsigned DIV = 105
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       restart,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    quarter_q, quarter_d;

  assign tick    = !restart && (cnt_q == CntMax);
  assign quarter = quarter_q;

  always_comb begin
    cnt_d     = cnt_q;
    quarter_d = quarter_q;
    if (restart) begin
      cnt_d     = '0;
      quarter_d = 2'd0;
    end else if (cnt_q == CntMax) begin
      cnt_d     = '0;
      quarter_d = quarter_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      quarter_q <= 2'd0;
    end else begin
      cnt_q     <= cnt_d;
      quarter_q <= quarter_d;
    end
  end

endmodule

// File: rtl/i2c_cmos_master.sv
// Byte-level I2C initiator for single-byte random writes/reads to a 24C0x EEPROM.
// SCL/SDA are open-drain style drives (1 = released) decoded from state and quarter.
module i2c_cmos_master
  import i2c_cmos_pkg::*;
#(
  parameter int unsigned CLK_HZ = 42000000,
  parameter int unsigned I2C_HZ = 100000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       sda_i
);

  // Clocks per quarter-bit; must be at least 2.
  localparam int unsigned DIV = CLK_HZ / (4 * I2C_HZ);

  state_e     state_q, state_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rdata_q, rdata_d;
  logic       nack_flag_q, nack_flag_d;
  logic       nack_q, nack_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       tick;
  logic [1:0] quarter;
  logic       slot_end;
  logic       sample;
  logic       scl_hi_mid;
  logic [7:0] tx_cur;

  i2c_qtick #(
    .DIV(DIV)
  ) u_qtick (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .restart (state_q == StIdle),
    .tick    (tick),
    .quarter (quarter)
  );

  assign slot_end   = tick && (quarter == 2'd3);
  assign sample     = tick && (quarter == 2'd2);
  assign scl_hi_mid = (quarter == 2'd1) || (quarter == 2'd2);
  assign tx_cur     = tx_byte(byte_idx_q, we_q, addr_q, wdata_q);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    byte_idx_d  = byte_idx_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rdata_d     = rdata_q;
    nack_flag_d = nack_flag_q;
    nack_d      = nack_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d     = StStart;
          busy_d      = 1'b1;
          we_d        = we;
          addr_d      = addr;
          wdata_d     = wdata;
          byte_idx_d  = 2'd0;
          bit_cnt_d   = 3'd0;
          nack_flag_d = 1'b0;
          nack_d      = 1'b0;
        end
      end
      StStart: begin
        if (slot_end) state_d = StTx;
      end
      StTx: begin
        if (slot_end) begin
          if (bit_cnt_q == 3'd7) begin
            state_d   = StRack;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StRack: begin
        if (sample && sda_i) nack_flag_d = 1'b1;
        if (slot_end) begin
          byte_idx_d = byte_idx_q + 2'd1;
          bit_cnt_d  = 3'd0;
          // The flag was sampled at q2, so it is already settled at slot end.
          if (nack_flag_q) begin
            state_d = StStop;
          end else begin
            unique case (byte_idx_q)
              2'd0:    state_d = StTx;
              2'd1:    state_d = we_q ? StTx : StRestart;
              default: state_d = we_q ? StStop : StRx;
            endcase
          end
        end
      end
      StRestart: begin
        if (slot_end) state_d = StTx;
      end
      StRx: begin
        if (sample) shift_d = {shift_q[6:0], sda_i};
        if (slot_end) begin
          if (bit_cnt_q == 3'd7) begin
            state_d   = StMnack;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StMnack: begin
        if (slot_end) state_d = StStop;
      end
      StStop: begin
        if (slot_end) begin
          state_d = StFin;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          nack_d  = nack_flag_q;
          if (!we_q) rdata_d = shift_q;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Line drive per slot type and quarter.
  always_comb begin
    scl_o = 1'b1;
    sda_o = 1'b1;
    unique case (state_q)
      StStart: begin
        scl_o = (quarter != 2'd3);
        sda_o = (quarter < 2'd2);
      end
      StTx: begin
        scl_o = scl_hi_mid;
        sda_o = tx_cur[3'd7 - bit_cnt_q];
      end
      StRack, StRx, StMnack: begin
        scl_o = scl_hi_mid;
        sda_o = 1'b1;
      end
      StRestart: begin
        scl_o = scl_hi_mid;
        sda_o = (quarter < 2'd2);
      end
      StStop: begin
        scl_o = (quarter != 2'd0);
        sda_o = (quarter >= 2'd2);
      end
      default: begin
        scl_o = 1'b1;
        sda_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      byte_idx_q  <= 2'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rdata_q     <= 8'h00;
      nack_flag_q <= 1'b0;
      nack_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      byte_idx_q  <= byte_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      nack_flag_q <= nack_flag_d;
      nack_q      <= nack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign nack  = nack_q;

endmodule

// File: tb/tb_i2c_cmos_master.sv
// Bench for i2c_cmos_master at DIV=2: EEPROM responder model, per-cycle slot-level
// reference model of the line waveforms/handshake, and directed plus random transactions.
module tb_i2c_cmos_master;
  import i2c_cmos_pkg::*;

  localparam int D = 2;
  localparam int K_BIT = 0, K_START = 1, K_RST = 2, K_STOP = 3;
  localparam int PH_IDLE = 0, PH_RX = 1, PH_ACK = 2, PH_TX = 3, PH_MACK = 4;

  logic       clk_sys, reset_n, req, we, sda_i;
  logic [7:0] addr, wdata, rdata;
  logic       busy, done, nack, scl_o, sda_o;
  logic       resp_sda, resp_en;

  int checks = 0;
  int errors = 0;

  assign sda_i = sda_o & resp_sda;

  i2c_cmos_master #(
    .CLK_HZ(800000),
    .I2C_HZ(100000)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .nack    (nack),
    .scl_o   (scl_o),
    .sda_o   (sda_o),
    .sda_i   (sda_i)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] preload(input int a);
    logic [7:0] v;
    v = 8'(a);
    return (v == 8'h7F) ? 8'hC3 : (v ^ 8'h3C);
  endfunction

  // ---------------- EEPROM responder / bus monitor ----------------
  logic [7:0] resp_mem[256];
  logic [7:0] rlog[$];
  int         n_start = 0, n_stop = 0, n_mack = 0;
  logic       mack_last = 1'b0;

  initial begin
    int ph, cnt, bnum;
    logic p_scl, p_sda, b_scl, b_sda, rdmode, mack;
    logic [7:0] sh, tx, ptr;
    for (int a = 0; a < 256; a++) resp_mem[a] = preload(a);
    resp_sda = 1'b1;
    ph = PH_IDLE; cnt = 0; bnum = 0; rdmode = 1'b0; mack = 1'b1;
    sh = 8'h00; tx = 8'h00; ptr = 8'h00; p_scl = 1'b1; p_sda = 1'b1;
    forever begin
      @(negedge clk_sys);
      b_scl = scl_o;
      b_sda = sda_i;
      if (!reset_n) begin
        ph = PH_IDLE;
        resp_sda = 1'b1;
      end else if (p_scl && b_scl && p_sda && !b_sda) begin
        n_start++;
        ph = resp_en ? PH_RX : PH_IDLE;
        cnt = 0; bnum = 0; rdmode = 1'b0; resp_sda = 1'b1;
      end else if (p_scl && b_scl && !p_sda && b_sda) begin
        n_stop++;
        ph = PH_IDLE;
        resp_sda = 1'b1;
      end else if (!p_scl && b_scl) begin
        if (ph == PH_RX) begin
          sh = {sh[6:0], b_sda};
          cnt++;
        end else if (ph == PH_MACK) begin
          mack = b_sda;
          mack_last = b_sda;
          n_mack++;
        end
      end else if (p_scl && !b_scl) begin
        case (ph)
          PH_RX: begin
            if (cnt == 8) begin
              rlog.push_back(sh);
              ph = PH_ACK;
              resp_sda = 1'b0;
              if (bnum == 0) begin
                if (sh[7:1] == 7'h50) rdmode = sh[0];
                else begin
                  ph = PH_IDLE;
                  resp_sda = 1'b1;
                end
              end else if (bnum == 1) begin
                ptr = sh;
              end else begin
                resp_mem[ptr] = sh;
                ptr = ptr + 8'd1;
              end
              bnum++;
            end
          end
          PH_ACK: begin
            resp_sda = 1'b1;
            cnt = 0;
            if (rdmode) begin
              tx = resp_mem[ptr];
              ptr = ptr + 8'd1;
              resp_sda = tx[7];
              ph = PH_TX;
            end else begin
              ph = PH_RX;
            end
          end
          PH_TX: begin
            cnt++;
            if (cnt == 8) begin
              resp_sda = 1'b1;
              ph = PH_MACK;
            end else begin
              resp_sda = tx[7-cnt];
            end
          end
          PH_MACK: begin
            if (!mack) begin
              tx = resp_mem[ptr];
              ptr = ptr + 8'd1;
              cnt = 0;
              resp_sda = tx[7];
              ph = PH_TX;
            end else begin
              ph = PH_IDLE;
            end
          end
          default: ;
        endcase
      end
      p_scl = b_scl;
      p_sda = b_sda;
    end
  end

  // ---------------- Reference model + per-cycle compare ----------------
  int         sl_kind[64];
  bit         sl_bit[64];
  int         n_sl;
  logic [7:0] ref_mem[256];

  task automatic push_slot(input int k, input bit b);
    sl_kind[n_sl] = k;
    sl_bit[n_sl]  = b;
    n_sl++;
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) push_slot(K_BIT, v[i]);
    push_slot(K_BIT, 1'b1);  // ACK slot: initiator releases SDA
  endtask

  initial begin
    bit         m_active, m_we, m_en;
    int         m_k, m_L, s, q;
    logic [7:0] m_addr, m_wdata;
    bit         e_scl, e_sda;
    for (int a = 0; a < 256; a++) ref_mem[a] = preload(a);
    m_active = 0; m_we = 0; m_en = 0; m_k = 0; m_L = 0; m_addr = 0; m_wdata = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        chk("rst_scl", scl_o, 1); chk("rst_sda", sda_o, 1);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_nack", nack, 0); chk("rst_rdata", rdata, 0);
        m_active = 0;
      end else if (m_active) begin
        if (m_k < m_L) begin
          s = m_k / (4 * D);
          q = (m_k / D) % 4;
          case (sl_kind[s])
            K_START: begin e_scl = (q != 3); e_sda = (q < 2); end
            K_RST:   begin e_scl = (q == 1 || q == 2); e_sda = (q < 2); end
            K_STOP:  begin e_scl = (q != 0); e_sda = (q >= 2); end
            default: begin e_scl = (q == 1 || q == 2); e_sda = sl_bit[s]; end
          endcase
          chk("cyc_busy", busy, 1); chk("cyc_done", done, 0);
          chk("cyc_scl", scl_o, e_scl); chk("cyc_sda", sda_o, e_sda);
          m_k++;
        end else begin
          chk("fin_busy", busy, 0); chk("fin_done", done, 1);
          chk("fin_nack", nack, !m_en);
          chk("fin_scl", scl_o, 1); chk("fin_sda", sda_o, 1);
          if (m_en && !m_we) chk("fin_rdata", rdata, ref_mem[m_addr]);
          if (m_en && m_we) ref_mem[m_addr] = m_wdata;
          m_active = 0;  // FIN returns to IDLE; no accept on this edge
        end
      end else begin
        chk("idle_busy", busy, 0); chk("idle_done", done, 0);
        chk("idle_scl", scl_o, 1); chk("idle_sda", sda_o, 1);
        if (req) begin
          m_active = 1; m_k = 0;
          m_we = we; m_addr = addr; m_wdata = wdata; m_en = resp_en;
          n_sl = 0;
          push_slot(K_START, 1'b1);
          push_byte(8'hA0);
          if (m_en) begin
            push_byte(m_addr);
            if (m_we) begin
              push_byte(m_wdata);
            end else begin
              push_slot(K_RST, 1'b1);
              push_byte(8'hA1);
              push_byte(8'hFF);  // RX bits released, then master NACK
            end
          end
          push_slot(K_STOP, 1'b1);
          m_L = n_sl * 4 * D;
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic run_txn(input bit w, input logic [7:0] a, input logic [7:0] d,
                         input bit pulse, output int lat);
    bit ok;
    @(posedge clk_sys); #1;
    we = w; addr = a; wdata = d; req = 1'b1;
    ok = 0; lat = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk_sys);
      if (busy) ok = 1;
    end
    if (!ok) begin
      chk("accept_timeout", busy, 1);
      @(posedge clk_sys); #1 req = 1'b0;
      return;
    end
    for (int t = 1; t <= 200 * 4 * D && lat == 0; t++) begin
      @(posedge clk_sys); #1;
      if (pulse && t < 40) begin
        req = 1'($urandom_range(0, 1));
        we  = 1'($urandom_range(0, 1));
      end else begin
        req = 1'b0;
      end
      @(negedge clk_sys);
      if (done) lat = t;
    end
    if (lat == 0) chk("done_timeout", done, 1);
  endtask

  initial begin
    int lat, n0, s0, p0, m0, ndone, d1, acc2;
    bit pb;
    logic [7:0] ra, rd;
    reset_n = 1'b0; req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00; resp_en = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_scl", scl_o, 1); chk("reset_sda", sda_o, 1); chk("reset_busy", busy, 0);
    chk("reset_done", done, 0); chk("reset_nack", nack, 0); chk("reset_rdata", rdata, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);

    // Write 0x40 <= 0x5A
    n0 = rlog.size(); s0 = n_start; p0 = n_stop;
    run_txn(1'b1, 8'h40, 8'h5A, 1'b0, lat);
    chk("wr_latency", lat, 232);
    chk("wr_latency_pkg", lat, WR_SLOTS * 4 * D);
    chk("wr_nack", nack, 0);
    chk("wr_ram", resp_mem[8'h40], 8'h5A);
    chk("wr_nbytes", rlog.size() - n0, 3);
    if (rlog.size() - n0 == 3) begin
      chk("wr_byte0", rlog[n0], 8'hA0); chk("wr_byte1", rlog[n0+1], 8'h40);
      chk("wr_byte2", rlog[n0+2], 8'h5A);
    end
    chk("wr_starts", n_start - s0, 1); chk("wr_stops", n_stop - p0, 1);

    // Read preloaded 0x7F
    n0 = rlog.size(); s0 = n_start; p0 = n_stop; m0 = n_mack;
    run_txn(1'b0, 8'h7F, 8'h00, 1'b0, lat);
    chk("rd_latency", lat, 312);
    chk("rd_latency_pkg", lat, RD_SLOTS * 4 * D);
    chk("rd_rdata", rdata, 8'hC3);
    chk("rd_nack", nack, 0);
    chk("rd_master_nack", mack_last, 1); chk("rd_mack_count", n_mack - m0, 1);
    chk("rd_starts", n_start - s0, 2); chk("rd_stops", n_stop - p0, 1);
    if (rlog.size() - n0 == 3) chk("rd_byte2", rlog[n0+2], 8'hA1);
    else chk("rd_nbytes", rlog.size() - n0, 3);

    // No responder
    @(posedge clk_sys); #1 resp_en = 1'b0;
    s0 = n_start; p0 = n_stop;
    run_txn(1'b1, 8'h22, 8'h11, 1'b0, lat);
    chk("nr_latency", lat, 88);
    chk("nr_nack", nack, 1);
    chk("nr_starts", n_start - s0, 1); chk("nr_stops", n_stop - p0, 1);
    chk("nr_ram_kept", resp_mem[8'h22], preload(8'h22));
    @(posedge clk_sys); #1 resp_en = 1'b1;

    // Reset in the middle of the second TX byte (slot 12, q0)
    @(posedge clk_sys); #1;
    we = 1'b1; addr = 8'h33; wdata = 8'h99; req = 1'b1;
    lat = 0;
    for (int i = 0; i < 8 && lat == 0; i++) begin
      @(negedge clk_sys);
      if (busy) lat = 1;
    end
    chk("mr_accept", lat, 1);
    for (int t = 1; t <= 48 * D; t++) begin
      @(posedge clk_sys); #1 req = 1'b0;
      @(negedge clk_sys);
    end
    chk("mr_pre_scl", scl_o, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("mr_async_scl", scl_o, 1); chk("mr_async_sda", sda_o, 1); chk("mr_async_busy", busy, 0);
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    run_txn(1'b1, 8'h10, 8'hE7, 1'b0, lat);
    chk("mr_wr_latency", lat, 232); chk("mr_wr_nack", nack, 0);
    chk("mr_ram10", resp_mem[8'h10], 8'hE7);
    chk("mr_ram33_kept", resp_mem[8'h33], preload(8'h33));
    run_txn(1'b0, 8'h10, 8'h00, 1'b0, lat);
    chk("mr_rd_rdata", rdata, 8'hE7);

    // Back-to-back: req held high across two writes
    @(posedge clk_sys); #1;
    we = 1'b1; addr = 8'h05; wdata = 8'h81; req = 1'b1;
    ndone = 0; d1 = -1; acc2 = -1; pb = 1'b1;
    for (int i = 0; i < 8 && !busy; i++) @(negedge clk_sys);
    chk("b2b_accept1", busy, 1);
    for (int t = 1; t <= 2 * WR_SLOTS * 4 * D + 40; t++) begin
      @(posedge clk_sys); #1;
      if (t == 1) begin addr = 8'h06; wdata = 8'h7E; end
      if (acc2 >= 0) req = 1'b0;
      @(negedge clk_sys);
      if (done) begin
        ndone++;
        if (d1 < 0) d1 = t;
      end
      if (busy && !pb && acc2 < 0) acc2 = t;
      pb = busy;
    end
    chk("b2b_done_count", ndone, 2);
    // Done cycle is FIN; one IDLE cycle follows, then the accept edge.
    chk("b2b_reaccept_gap", acc2 - d1, 2);
    chk("b2b_ram05", resp_mem[8'h05], 8'h81); chk("b2b_ram06", resp_mem[8'h06], 8'h7E);

    // Random traffic with req/we noise while busy
    for (int n = 0; n < 12; n++) begin
      ra = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      run_txn(1'b1, ra, rd, 1'b1, lat);
      chk("rnd_wr_latency", lat, 232); chk("rnd_wr_nack", nack, 0);
      run_txn(1'b0, ra, 8'h00, 1'b1, lat);
      chk("rnd_rd_latency", lat, 312);
      chk("rnd_rd_rdata", rdata, rd);
    end

    // Address 0xFF round-trip
    run_txn(1'b1, 8'hFF, 8'h6B, 1'b0, lat);
    chk("ff_wr_latency", lat, 232);
    run_txn(1'b0, 8'hFF, 8'h00, 1'b0, lat);
    chk("ff_rd_latency", lat, 312);
    chk("ff_rdata", rdata, 8'h6B);

    repeat (4) @(posedge clk_sys);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
